mc_control_unit: RTL and testbench
==================================

// Module: mc_control_unit
// PURPOSE
//  Multicycle ARM-subset control unit. It replaces the single-cycle combinational decoder.
//  A Moore FSM sequences FETCH/DECODE/EXEC/MEM/WB over the shared-memory datapath.
//  Adds configurable memory wait states, an optional iterative MUL, and condition-fail early abort.
//  Instr is the registered IR output; CondEx comes from the condition/flags unit.
// PARAMETERS
//  MEM_LAT     1  cycles per instr/data memory access (>=1); FETCH/MEMRD/MEMWR hold this long
//  MUL_EN      0  1: decode MUL (Instr[27:22]=0, Instr[7:4]=4'b1001); 0: pattern decodes as DP-reg
//  MUL_CYCLES  4  cycles spent in MULEX (>=1)
// PORTS
//  CLK         in   1   clock, rising edge
//  RESET_N     in   1   synchronous, active-low reset
//  Instr       in   32  current IR contents
//  CondEx      in   1   condition passed; sampled only in DECODE
//  PCWrite     out  1   PC register enable
//  IRWrite     out  1   IR enable
//  RegW        out  1   register-file write enable
//  MemW        out  1   data-memory write enable
//  AdrSrc      out  1   0: PC, 1: ALUResult register, as memory address
//  ALUSrcA     out  1   0: RD1, 1: PC
//  ALUSrcB     out  2   00: RD2, 01: ExtImm, 10: const 4
//  ResultSrc   out  2   00: ALUOut, 01: Data, 10: ALUResult, 11: multiplier result
//  ImmSrc      out  2   Instr[27:26]
//  RegSrc      out  2   {store ? 1 : 0, branch ? 1 : 0}
//  ALUControl  out  2   00 ADD, 01 SUB, 10 AND, 11 ORR
//  FlagW       out  2   [1]: NZ write, [0]: CV write
//  MulStart    out  1   1-cycle pulse on MULEX entry
//  MulDst      out  1   1: write address is Instr[19:16] (MUL Rd)
//  Undef       out  1   1-cycle pulse; undefined op (op=11) seen in DECODE
//  State       out  4   current state encoding, for debug
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, MULEX.
//  Reset (RESET_N=0 at an edge): state<=FETCH, wait counter<=0.
//   While RESET_N=0, PCWrite/IRWrite/RegW/MemW/MulStart/Undef are forced 0 combinationally.
//   All other outputs are 0 during reset. Reset mid-instruction abandons it; no partial writes follow.
//  Wait counter: width clog2(max(MEM_LAT,MUL_CYCLES)+1).
//   It counts in FETCH, MEMRD, MEMWR and MULEX, and clears on every state change.
//  FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD.
//   IRWrite and PCWrite pulse only in the last of the MEM_LAT cycles; then go to DECODE.
//  DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD.
//   CondEx=0 -> FETCH, no writes.
//   op=11 -> Undef=1, then FETCH.
//   Otherwise: op=01 -> MEMADR; op=10 -> BRANCH; MUL (MUL_EN=1) -> MULEX;
//   op=00 with I=1 -> EXECI; op=00 with I=0 -> EXECR.
//  MEMADR: ALUSrcA=0, ALUSrcB=01. U=Instr[23]: 1=ADD, 0=SUB.
//   L=Instr[20]: 1 -> MEMRD, 0 -> MEMWR.
//  MEMRD: AdrSrc=1 for MEM_LAT cycles, then MEMWB.
//  MEMWB: ResultSrc=01, RegW=1. PCWrite=1 if Rd=15. Then FETCH.
//  MEMWR: AdrSrc=1. MemW=1 only in the last of the MEM_LAT cycles; then FETCH.
//  EXECR/EXECI: ALUSrcB=00 (EXECR) or 01 (EXECI); 1 cycle, then ALUWB.
//   cmd=Instr[24:21], S=Instr[20]:
//   ADD 0100->00, SUB 0010->01, AND 0000->10, ORR 1100->11, CMP 1010->01, CMN 1011->00.
//   FlagW=S ? (ADD/SUB/CMP/CMN: 11, AND/ORR: 10) : 00; asserted only in EXECR/EXECI.
//   Unsupported cmd: ALUControl=00, FlagW=00, and the instr is treated as NoWrite.
//  ALUWB: ResultSrc=00 (11 after MULEX). RegW=~NoWrite, where NoWrite covers CMP/CMN/unsupported.
//   PCWrite=1 if Rd=15 and RegW=1. Then FETCH.
//  MULEX: MulStart=1 in the first cycle only; stay MUL_CYCLES cycles, then ALUWB.
//   In that ALUWB: MulDst=1, PCWrite=0 always.
//  BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=1; then FETCH.
//  Defaults: any output not listed for a state is 0.
//  Cycles per instr (MEM_LAT=1): DP 4, LDR 5, STR 4, B 3.
//   Each memory access state adds MEM_LAT-1 cycles.
// TESTING
//  Reset: hold RESET_N=0 for 3 cycles with a random Instr.
//   -> State=FETCH, all enables 0; first IRWrite 1 cycle after release.
//  ADD R1,R2,R3 (0xE0821003), MEM_LAT=1.
//   -> FETCH, DECODE, EXECR, ALUWB; RegW=1 in cycle 4 only; FlagW=00.
//  LDR R0,[R1,#-4] (0xE5110004), MEM_LAT=3.
//   -> 9 cycles; ALUControl=01 in MEMADR; RegW in cycle 9; IRWrite in cycle 3.
//  CMP R0,#5 (0xE3500005) -> FlagW=11 in EXECI; RegW=0 in ALUWB.
//   Same encoding with CondEx=0 -> DECODE returns to FETCH; FlagW never set.
//  MUL R2,R0,R1 (0xE0020190), MUL_EN=1, MUL_CYCLES=4.
//   -> 7 cycles; MulStart 1 pulse; MulDst=1 and ResultSrc=11 in ALUWB.
//   With MUL_EN=0 -> EXECR path, ALUControl=10.
//  Reset asserted in MEMWR of a STR with MEM_LAT=4.
//   -> MemW never asserted; FETCH restarts cleanly.
//   Op=11 instr -> Undef pulses 1 cycle in DECODE.

Source files
------------

// File: rtl/mc_control_unit_if.sv
// Control/status bundle between the multicycle control unit and its datapath.
// The slave side is the control unit; the master side is the datapath (or a bench).
interface mc_control_unit_if;
  logic [31:0] instr;
  logic        condex;
  logic        pcwrite;
  logic        irwrite;
  logic        regw;
  logic        memw;
  logic        adrsrc;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic [1:0]  resultsrc;
  logic [1:0]  immsrc;
  logic [1:0]  regsrc;
  logic [1:0]  alucontrol;
  logic [1:0]  flagw;
  logic        mulstart;
  logic        muldst;
  logic        undef;
  logic [3:0]  state;

  modport master (
    output instr, condex,
    input  pcwrite, irwrite, regw, memw, adrsrc, alusrca, alusrcb, resultsrc,
           immsrc, regsrc, alucontrol, flagw, mulstart, muldst, undef, state
  );

  modport slave (
    input  instr, condex,
    output pcwrite, irwrite, regw, memw, adrsrc, alusrca, alusrcb, resultsrc,
           immsrc, regsrc, alucontrol, flagw, mulstart, muldst, undef, state
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle ARM-subset control unit: Moore FSM over a shared-memory datapath with
// memory wait states, optional iterative MUL and condition-fail early abort.
//
// state  | meaning
// FETCH  | read instr at PC, PC+4 written back in the last memory cycle
// DECODE | condition check, dispatch on op
// MEMADR | compute load/store address (base +/- imm)
// MEMRD  | data memory read, MEM_LAT cycles
// MEMWB  | write loaded data to Rd
// MEMWR  | data memory write, strobe in the last MEM_LAT cycle
// EXECR  | DP with register operand
// EXECI  | DP with immediate operand
// ALUWB  | write ALU or multiplier result to Rd
// BRANCH | PC <= PC+8+imm
// MULEX  | iterative multiply, MUL_CYCLES cycles
module mc_control_unit #(
  parameter int MEM_LAT    = 1,
  parameter int MUL_EN     = 0,
  parameter int MUL_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  mc_control_unit_if.slave bus
);

  localparam int CNT_MAX = (MEM_LAT > MUL_CYCLES) ? MEM_LAT : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MEM_LAST = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_MULEX  = 4'd10
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic          from_mul;

  logic [1:0] op;
  logic [3:0] cmd;
  logic       rd15;
  logic       is_mul;
  logic       mem_last;
  logic       mul_last;
  logic       unused_bits;

  assign op       = bus.instr[27:26];
  assign cmd      = bus.instr[24:21];
  assign rd15     = (bus.instr[15:12] == 4'hf);
  assign is_mul   = (MUL_EN != 0) && (bus.instr[27:22] == 6'b0) && (bus.instr[7:4] == 4'b1001);
  assign mem_last = (cnt == MEM_LAST);
  assign mul_last = (cnt == MUL_LAST);
  assign unused_bits = ^{bus.instr[31:28], bus.instr[19:16], bus.instr[11:8], bus.instr[3:0]};

  // DP command decode; unsupported commands fall back to ADD with no write and no flags.
  logic [1:0] dp_alu;
  logic       dp_arith;
  logic       dp_supp;
  logic       dp_nowrite;
  always_comb begin
    dp_alu     = 2'b00;
    dp_arith   = 1'b0;
    dp_supp    = 1'b1;
    dp_nowrite = 1'b0;
    case (cmd)
      4'b0100: begin dp_alu = 2'b00; dp_arith = 1'b1; end
      4'b0010: begin dp_alu = 2'b01; dp_arith = 1'b1; end
      4'b0000: dp_alu = 2'b10;
      4'b1100: dp_alu = 2'b11;
      4'b1010: begin dp_alu = 2'b01; dp_arith = 1'b1; dp_nowrite = 1'b1; end
      4'b1011: begin dp_alu = 2'b00; dp_arith = 1'b1; dp_nowrite = 1'b1; end
      default: begin dp_supp = 1'b0; dp_nowrite = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st       <= S_FETCH;
      cnt      <= '0;
      from_mul <= 1'b0;
    end else begin
      cnt <= '0;
      case (st)
        S_FETCH:  if (mem_last) st <= S_DECODE; else cnt <= cnt + 1'b1;
        S_DECODE: begin
          from_mul <= 1'b0;
          if (!bus.condex || op == 2'b11) st <= S_FETCH;
          else if (op == 2'b01)           st <= S_MEMADR;
          else if (op == 2'b10)           st <= S_BRANCH;
          else if (is_mul) begin
            st       <= S_MULEX;
            from_mul <= 1'b1;
          end
          else if (bus.instr[25])         st <= S_EXECI;
          else                            st <= S_EXECR;
        end
        S_MEMADR: st <= bus.instr[20] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_last) st <= S_MEMWB; else cnt <= cnt + 1'b1;
        S_MEMWR:  if (mem_last) st <= S_FETCH; else cnt <= cnt + 1'b1;
        S_EXECR,
        S_EXECI:  st <= S_ALUWB;
        S_MULEX:  if (mul_last) st <= S_ALUWB; else cnt <= cnt + 1'b1;
        default:  st <= S_FETCH;
      endcase
    end
  end

  logic       o_pcw, o_irw, o_regw, o_memw, o_adr, o_srca, o_mulst, o_muldst, o_undef;
  logic [1:0] o_srcb, o_res, o_alu, o_flagw;

  always_comb begin
    o_pcw = 1'b0; o_irw = 1'b0; o_regw = 1'b0; o_memw = 1'b0; o_adr = 1'b0;
    o_srca = 1'b0; o_mulst = 1'b0; o_muldst = 1'b0; o_undef = 1'b0;
    o_srcb = 2'b00; o_res = 2'b00; o_alu = 2'b00; o_flagw = 2'b00;
    case (st)
      S_FETCH: begin
        o_srca = 1'b1; o_srcb = 2'b10; o_res = 2'b10;
        o_irw  = mem_last;
        o_pcw  = mem_last;
      end
      S_DECODE: begin
        o_srca  = 1'b1; o_srcb = 2'b10; o_res = 2'b10;
        o_undef = bus.condex && (op == 2'b11);
      end
      S_MEMADR: begin
        o_srcb = 2'b01;
        o_alu  = bus.instr[23] ? 2'b00 : 2'b01;
      end
      S_MEMRD: o_adr = 1'b1;
      S_MEMWB: begin
        o_res = 2'b01; o_regw = 1'b1; o_pcw = rd15;
      end
      S_MEMWR: begin
        o_adr = 1'b1; o_memw = mem_last;
      end
      S_EXECR, S_EXECI: begin
        o_srcb  = (st == S_EXECI) ? 2'b01 : 2'b00;
        o_alu   = dp_alu;
        o_flagw = (bus.instr[20] && dp_supp) ? (dp_arith ? 2'b11 : 2'b10) : 2'b00;
      end
      S_ALUWB: begin
        // A MUL writeback never targets the PC and ignores the DP write-suppress decode.
        if (from_mul) begin
          o_res = 2'b11; o_regw = 1'b1; o_muldst = 1'b1;
        end else begin
          o_regw = !dp_nowrite;
          o_pcw  = !dp_nowrite && rd15;
        end
      end
      S_BRANCH: begin
        o_srcb = 2'b01; o_res = 2'b10; o_pcw = 1'b1;
      end
      S_MULEX: o_mulst = (cnt == '0);
      default: ;
    endcase
  end

  assign bus.pcwrite    = reset_n & o_pcw;
  assign bus.irwrite    = reset_n & o_irw;
  assign bus.regw       = reset_n & o_regw;
  assign bus.memw       = reset_n & o_memw;
  assign bus.adrsrc     = reset_n & o_adr;
  assign bus.alusrca    = reset_n & o_srca;
  assign bus.mulstart   = reset_n & o_mulst;
  assign bus.muldst     = reset_n & o_muldst;
  assign bus.undef      = reset_n & o_undef;
  assign bus.alusrcb    = reset_n ? o_srcb  : 2'b00;
  assign bus.resultsrc  = reset_n ? o_res   : 2'b00;
  assign bus.alucontrol = reset_n ? o_alu   : 2'b00;
  assign bus.flagw      = reset_n ? o_flagw : 2'b00;
  assign bus.immsrc     = reset_n ? op : 2'b00;
  assign bus.regsrc     = reset_n ? {op == 2'b01 && !bus.instr[20], op == 2'b10} : 2'b00;
  assign bus.state      = reset_n ? st : 4'd0;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: three parameterisations run the same instruction stream and
// are compared every cycle against an expected per-cycle sequence built from the ISA rules.
module tb_mc_control_unit;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, regw, memw, adr, srca;
    logic [1:0] srcb, res, imm, regsrc, aluc, flagw;
    logic       mulst, muldst, undef;
  } ov_t;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                         ALUWB = 4'd8, BRANCH = 4'd9, MULEX = 4'd10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        condex;

  always #5 clk = ~clk;

  mc_control_unit_if if_a ();
  mc_control_unit_if if_b ();
  mc_control_unit_if if_c ();

  assign if_a.instr = instr;  assign if_a.condex = condex;
  assign if_b.instr = instr;  assign if_b.condex = condex;
  assign if_c.instr = instr;  assign if_c.condex = condex;

  mc_control_unit #(.MEM_LAT(1), .MUL_EN(1), .MUL_CYCLES(4)) dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  mc_control_unit #(.MEM_LAT(3), .MUL_EN(0), .MUL_CYCLES(2)) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  mc_control_unit #(.MEM_LAT(4), .MUL_EN(0), .MUL_CYCLES(3)) dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

  ov_t obs [3];
  assign obs[0] = {if_a.state, if_a.pcwrite, if_a.irwrite, if_a.regw, if_a.memw, if_a.adrsrc, if_a.alusrca,
                   if_a.alusrcb, if_a.resultsrc, if_a.immsrc, if_a.regsrc, if_a.alucontrol, if_a.flagw,
                   if_a.mulstart, if_a.muldst, if_a.undef};
  assign obs[1] = {if_b.state, if_b.pcwrite, if_b.irwrite, if_b.regw, if_b.memw, if_b.adrsrc, if_b.alusrca,
                   if_b.alusrcb, if_b.resultsrc, if_b.immsrc, if_b.regsrc, if_b.alucontrol, if_b.flagw,
                   if_b.mulstart, if_b.muldst, if_b.undef};
  assign obs[2] = {if_c.state, if_c.pcwrite, if_c.irwrite, if_c.regw, if_c.memw, if_c.adrsrc, if_c.alusrca,
                   if_c.alusrcb, if_c.resultsrc, if_c.immsrc, if_c.regsrc, if_c.alucontrol, if_c.flagw,
                   if_c.mulstart, if_c.muldst, if_c.undef};

  int lat   [3] = '{1, 3, 4};
  int mulen [3] = '{1, 0, 0};
  int mulc  [3] = '{4, 2, 3};

  ov_t exp_seq [3][0:31];
  int  exp_len [3];
  int  pos     [3];
  int  errors = 0;
  int  checks = 0;

  task automatic push(input int d, input ov_t e);
    exp_seq[d][exp_len[d]] = e;
    exp_len[d]++;
  endtask

  // Expected cycle-by-cycle outputs for one full pass of the current instruction on dut d.
  task automatic build(input int d);
    ov_t b, e;
    logic [1:0] op, aluc;
    logic rd15, is_mul, arith, supp, nowr;
    op   = instr[27:26];
    rd15 = (instr[15:12] == 4'hf);
    exp_len[d] = 0;
    b = '0;
    b.imm = op;
    b.regsrc = {op == 2'b01 && !instr[20], op == 2'b10};
    for (int k = 0; k < lat[d]; k++) begin
      e = b; e.st = FETCH; e.srca = 1; e.srcb = 2; e.res = 2;
      e.pcw = (k == lat[d] - 1); e.irw = e.pcw;
      push(d, e);
    end
    e = b; e.st = DECODE; e.srca = 1; e.srcb = 2; e.res = 2;
    e.undef = condex && op == 2'b11;
    push(d, e);
    if (!condex || op == 2'b11) return;
    is_mul = (mulen[d] != 0) && instr[27:22] == 6'd0 && instr[7:4] == 4'b1001;
    if (op == 2'b01) begin
      e = b; e.st = MEMADR; e.srcb = 1; e.aluc = instr[23] ? 2'b00 : 2'b01;
      push(d, e);
      for (int k = 0; k < lat[d]; k++) begin
        e = b; e.adr = 1;
        e.st = instr[20] ? MEMRD : MEMWR;
        e.memw = !instr[20] && (k == lat[d] - 1);
        push(d, e);
      end
      if (instr[20]) begin
        e = b; e.st = MEMWB; e.res = 1; e.regw = 1; e.pcw = rd15;
        push(d, e);
      end
    end else if (op == 2'b10) begin
      e = b; e.st = BRANCH; e.srcb = 1; e.res = 2; e.pcw = 1;
      push(d, e);
    end else if (is_mul) begin
      for (int k = 0; k < mulc[d]; k++) begin
        e = b; e.st = MULEX; e.mulst = (k == 0);
        push(d, e);
      end
      e = b; e.st = ALUWB; e.res = 3; e.regw = 1; e.muldst = 1;
      push(d, e);
    end else begin
      supp = 1; arith = 0; nowr = 0; aluc = 0;
      case (instr[24:21])
        4'b0100: begin aluc = 0; arith = 1; end
        4'b0010: begin aluc = 1; arith = 1; end
        4'b0000: aluc = 2;
        4'b1100: aluc = 3;
        4'b1010: begin aluc = 1; arith = 1; nowr = 1; end
        4'b1011: begin aluc = 0; arith = 1; nowr = 1; end
        default: begin supp = 0; nowr = 1; end
      endcase
      e = b; e.st = instr[25] ? EXECI : EXECR; e.srcb = instr[25] ? 2'b01 : 2'b00;
      e.aluc = aluc;
      e.flagw = (instr[20] && supp) ? (arith ? 2'b11 : 2'b10) : 2'b00;
      push(d, e);
      e = b; e.st = ALUWB; e.regw = !nowr; e.pcw = !nowr && rd15;
      push(d, e);
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      ov_t e;
      e = reset_n ? exp_seq[d][pos[d]] : '0;
      checks++;
      assert (obs[d] === e) else begin
        errors++;
        $error("FAIL %s dut%0d pos%0d: observed=%h expected=%h", tag, d, pos[d], obs[d], e);
      end
      if (reset_n) pos[d] = (pos[d] + 1) % exp_len[d];
    end
  endtask

  // Reset for rlen edges with a random IR, then run the given instruction for ncyc cycles.
  task automatic run_test(input string tag, input logic [31:0] ins, input logic cx,
                          input int ncyc, input int rlen);
    reset_n = 1'b0;
    instr   = $urandom;
    condex  = 1'($urandom);
    #1 check_all({tag, "_rst"});
    repeat (rlen) begin
      @(posedge clk); #1;
      check_all({tag, "_rst"});
    end
    reset_n = 1'b1;
    instr   = ins;
    condex  = cx;
    for (int d = 0; d < 3; d++) begin
      build(d);
      pos[d] = 0;
    end
    #1 check_all(tag);
    repeat (ncyc - 1) begin
      @(posedge clk); #1;
      check_all(tag);
    end
  endtask

  initial begin
    logic [31:0] ri;
    reset_n = 1'b0;
    instr   = '0;
    condex  = 1'b0;
    @(posedge clk); #1;

    run_test("add",       32'hE0821003, 1'b1, 12, 3);
    run_test("add_pc",    32'hE082F003, 1'b1, 10, 3);
    run_test("ldr",       32'hE5110004, 1'b1, 24, 3);
    run_test("ldr_pc",    32'hE591F000, 1'b1, 12, 2);
    run_test("cmp",       32'hE3500005, 1'b1, 10, 3);
    run_test("cmp_nocond",32'hE3500005, 1'b0, 10, 3);
    run_test("mul",       32'hE0020190, 1'b1, 16, 3);
    run_test("orrs",      32'hE1921003, 1'b1, 8, 1);
    run_test("str_abort", 32'hE5821008, 1'b1, 7, 3);
    run_test("after_str", 32'hE5821008, 1'b1, 24, 3);
    run_test("undef",     32'hEC000000, 1'b1, 6, 3);
    run_test("branch",    32'hEA000002, 1'b1, 9, 3);
    run_test("unsupp",    32'hE1F21003, 1'b1, 8, 3);

    for (int i = 0; i < 30; i++) begin
      ri = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: ri[27:26] = 2'b00;
        2: begin ri[27:22] = 6'd0; ri[7:4] = 4'b1001; end
        3: ri[27:26] = 2'b01;
        4: ri[27:26] = 2'b10;
        default: ri[27:26] = 2'b11;
      endcase
      run_test("rand", ri, $urandom_range(0, 3) != 0, $urandom_range(4, 30), $urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
